// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares the single-port program/data RAM between the CPU control unit and a
//   host port (program load / debug readback). Each access is a single-beat
//   read or write with a req/gnt handshake. The block sits between the CPU
//   datapath memory mux and the RAM macro.
//
//   A request seen in IDLE is granted on the next cycle. Every grant lasts one
//   cycle and is followed by an IDLE cycle, so the RAM sees at most one access
//   every two cycles. Grants are decoded from the state register only, so there
//   is no combinational path from any req input to any gnt output.
//
// Configuration:
//   ARB_RR_EN undefined (default): the CPU has priority. A saturating
//       starvation counter forces a host win after HOST_STARVE_MAX lost
//       contested arbitrations.
//   ARB_RR_EN defined: round-robin on contested cycles. The requester that
//       was not granted last wins. HOST_STARVE_MAX is unused in this build.
//   In both builds host_lock=1 hides cpu_req from the arbiter.
//
// Parameters:
//   AW               address width (RAM depth 2**AW)
//   DW               data width
//   HOST_STARVE_MAX  lost host arbitrations before the host is forced to win
//
// Ports:
//   clock, reset                 rising-edge clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata        CPU request (hold req until cpu_gnt is seen)
//   cpu_gnt, cpu_rvalid, cpu_rdata
//                                CPU grant, read-data-valid pulse, read data
//   host_req/we/addr/wdata       host request (same rules as the CPU)
//   host_lock                    1 = the CPU is never granted
//   host_gnt, host_rvalid, host_rdata
//                                host grant, read-data-valid pulse, read data
//   mem_addr, mem_wdata, mem_we  RAM address, write data and write strobe
//   mem_rdata                    RAM registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW              = 5,
    parameter int DW              = 8,
    parameter int HOST_STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_HOST = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic cpu_rvalid_reg;
    logic host_rvalid_reg;

    // Requests as the arbiter sees them: host_lock hides the CPU entirely.
    logic cpu_cand;
    logic host_cand;

    assign cpu_cand  = cpu_req & ~host_lock;
    assign host_cand = host_req;

`ifdef ARB_RR_EN
    // last_owner: 0 = CPU, 1 = host. Starts as CPU, so the first contested
    // arbitration after reset goes to the host.
    logic last_owner_reg;
    logic last_owner_next;

    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        case (state_reg)
            IDLE: begin
                if (cpu_cand && host_cand) begin
                    if (last_owner_reg) begin
                        state_next      = GNT_CPU;
                        last_owner_next = 1'b0;
                    end else begin
                        state_next      = GNT_HOST;
                        last_owner_next = 1'b1;
                    end
                end else if (cpu_cand) begin
                    state_next      = GNT_CPU;
                    last_owner_next = 1'b0;
                end else if (host_cand) begin
                    state_next      = GNT_HOST;
                    last_owner_next = 1'b1;
                end
            end
            GNT_CPU, GNT_HOST: state_next = IDLE;
            default:           state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_owner_reg <= 1'b0;
        end else begin
            last_owner_reg <= last_owner_next;
        end
    end
`else
    localparam int SW = $clog2(HOST_STARVE_MAX + 1);

    // Number of contested arbitrations the host has lost since its last grant.
    logic [SW-1:0] starve_cnt_reg;
    logic [SW-1:0] starve_cnt_next;
    logic          host_starved;

    assign host_starved = (starve_cnt_reg == SW'(HOST_STARVE_MAX));

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (cpu_cand && host_cand) begin
                    if (host_starved) begin
                        state_next      = GNT_HOST;
                        starve_cnt_next = '0;
                    end else begin
                        // Not yet saturated here, so the increment cannot wrap.
                        state_next      = GNT_CPU;
                        starve_cnt_next = starve_cnt_reg + 1'b1;
                    end
                end else if (cpu_cand) begin
                    state_next = GNT_CPU;
                end else if (host_cand) begin
                    state_next      = GNT_HOST;
                    starve_cnt_next = '0;
                end
            end
            GNT_CPU, GNT_HOST: state_next = IDLE;
            default:           state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            cpu_rvalid_reg  <= 1'b0;
            host_rvalid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            // The RAM returns read data one cycle after the grant cycle.
            cpu_rvalid_reg  <= (state_reg == GNT_CPU)  && !cpu_we;
            host_rvalid_reg <= (state_reg == GNT_HOST) && !host_we;
        end
    end

    assign cpu_gnt     = (state_reg == GNT_CPU);
    assign host_gnt    = (state_reg == GNT_HOST);
    assign cpu_rvalid  = cpu_rvalid_reg;
    assign host_rvalid = host_rvalid_reg;
    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = mem_rdata;

    // The RAM bus is driven from the state register alone, so an asynchronous
    // reset in the middle of a grant drops mem_we immediately.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state_reg)
            GNT_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
            end
            GNT_HOST: begin
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
                mem_we    = host_we;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
                mem_we    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed testbench for mem_arbiter with a 32x8 RAM model that has a
// registered read port. Each scenario task drives its own stimulus and checks
// the outputs against hand-computed values. Outputs are sampled 1 time unit
// after the rising clock edge. Build with +define+ARB_RR_EN to check the
// round-robin variant.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          host_req, host_we, host_lock;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.AW(AW), .DW(DW), .HOST_STARVE_MAX(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_lock  (host_lock),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    // RAM model: synchronous write, registered read; preloaded while ram_init=1.
    logic [DW-1:0] ram [0:31];
    logic          ram_init;

    always @(posedge clock) begin
        if (ram_init) begin
            for (int i = 0; i < 32; i++) ram[i] <= '0;
            ram[5] <= 8'h3C;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        host_lock = 0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset    = 1;
        ram_init = 1;
        tick();
        tick();
        ram_init = 0;
        total++;
        if ({cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_we} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got gnt/rv/we=%b required 00000",
                     {cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_we});
        end
        total++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            bad++;
            $display("FAIL reset_bus: got addr=%0h wdata=%0h required 0/0", mem_addr, mem_wdata);
        end
        reset = 0;
        tick();
        total++;
        if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req: got cpu_gnt=%b host_gnt=%b required 0/0", cpu_gnt, host_gnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_cpu_read;
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'd5;
        #1;
        total++;
        if (cpu_gnt !== 1'b0) begin
            bad++;
            $display("FAIL cpu_gnt_comb: got %b required 0 before the edge", cpu_gnt);
        end
        tick();
        total++;
        if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0 || mem_addr !== 5'd5 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL cpu_read_gnt: got gnt=%b hgnt=%b addr=%0d we=%b required 1 0 5 0",
                     cpu_gnt, host_gnt, mem_addr, mem_we);
        end
        cpu_req = 0;
        tick();
        total++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h3C || cpu_gnt !== 1'b0) begin
            bad++;
            $display("FAIL cpu_read_data: got rvalid=%b rdata=%0h gnt=%b required 1 3c 0",
                     cpu_rvalid, cpu_rdata, cpu_gnt);
        end
        tick();
        total++;
        if (cpu_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL cpu_rvalid_pulse: got %b required 0", cpu_rvalid);
        end
        $display("cpu read addr 5 -> rdata %0h", cpu_rdata);
    endtask

    task automatic test_host_write_read;
        host_req = 1; host_we = 1; host_addr = 5'd31; host_wdata = 8'hA5;
        tick();
        total++;
        if (host_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'd31 || mem_wdata !== 8'hA5) begin
            bad++;
            $display("FAIL host_write_gnt: got gnt=%b we=%b addr=%0d wdata=%0h required 1 1 31 a5",
                     host_gnt, mem_we, mem_addr, mem_wdata);
        end
        host_req = 0;
        tick();
        total++;
        if (mem_we !== 1'b0 || host_rvalid !== 1'b0 || mem_wdata !== '0) begin
            bad++;
            $display("FAIL host_write_after: got we=%b rvalid=%b wdata=%0h required 0 0 0",
                     mem_we, host_rvalid, mem_wdata);
        end
        $display("host write addr 31 data a5");
        host_req = 1; host_we = 0; host_wdata = 8'h00;
        tick();
        total++;
        if (host_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd31) begin
            bad++;
            $display("FAIL host_read_gnt: got gnt=%b we=%b addr=%0d required 1 0 31",
                     host_gnt, mem_we, mem_addr);
        end
        host_req = 0;
        tick();
        total++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'hA5 || cpu_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL host_read_data: got rvalid=%b rdata=%0h cpu_rvalid=%b required 1 a5 0",
                     host_rvalid, host_rdata, cpu_rvalid);
        end
        $display("host read addr 31 -> rdata %0h", host_rdata);
    endtask

    task automatic test_both_requests;
        logic [8*10-1:0] got_seq;
        logic [8*10-1:0] exp_seq;
        logic [7:0]      exp_c;
        int  ngr;
        int  cyc;
        logic prev_gnt;
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'd3;
        host_req = 1; host_we = 0; host_addr = 5'd9;
        ngr = 0; cyc = 0; prev_gnt = 0;
        got_seq = '0; exp_seq = '0;
        while (ngr < 10 && cyc < 40) begin
            tick();
            cyc++;
            if (cpu_gnt && host_gnt) begin
                total++; bad++;
                $display("FAIL both_dual_gnt: got both grants in cycle %0d required one", cyc);
            end
            if (cpu_gnt || host_gnt) begin
`ifdef ARB_RR_EN
                exp_c = (ngr % 2 == 0) ? "H" : "C";
`else
                exp_c = (ngr % 5 == 4) ? "H" : "C";
`endif
                total++;
                if (prev_gnt) begin
                    bad++;
                    $display("FAIL both_idle_gap: got back-to-back grants at cycle %0d required IDLE between", cyc);
                end
                total++;
                if ((cpu_gnt ? 8'("C") : 8'("H")) !== exp_c) begin
                    bad++;
                    $display("FAIL both_order: got %s at grant %0d required %s",
                             cpu_gnt ? "C" : "H", ngr, exp_c);
                end
                total++;
                if (mem_addr !== (cpu_gnt ? 5'd3 : 5'd9)) begin
                    bad++;
                    $display("FAIL both_addr: got %0d at grant %0d required %0d",
                             mem_addr, ngr, cpu_gnt ? 3 : 9);
                end
                got_seq = {got_seq[8*9-1:0], cpu_gnt ? 8'("C") : 8'("H")};
                exp_seq = {exp_seq[8*9-1:0], exp_c};
                ngr++;
            end
            prev_gnt = cpu_gnt | host_gnt;
        end
        total++;
        if (ngr != 10) begin
            bad++;
            $display("FAIL both_timeout: got %0d grants in %0d cycles required 10", ngr, cyc);
        end
        $display("both requests grant sequence %s (expected %s)", got_seq, exp_seq);
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_host_lock;
        int nc;
        int nh;
        int waited;
        apply_reset();
        host_lock = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'd2;
        host_req = 1; host_we = 0; host_addr = 5'd4;
        nc = 0; nh = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_gnt) nc++;
            if (host_gnt) nh++;
        end
        total++;
        if (nc != 0) begin
            bad++;
            $display("FAIL lock_cpu_blocked: got %0d cpu grants required 0", nc);
        end
        total++;
        if (nh != 10) begin
            bad++;
            $display("FAIL lock_host_served: got %0d host grants required 10", nh);
        end
        host_lock = 0;
        host_req  = 0;
        waited = 0;
        while (!cpu_gnt && waited < 2) begin
            tick();
            waited++;
        end
        total++;
        if (cpu_gnt !== 1'b1) begin
            bad++;
            $display("FAIL unlock_cpu_gnt: got no cpu_gnt within %0d cycles required within 2", waited);
        end
        $display("host_lock: cpu grants %0d, host grants %0d, unlock latency %0d", nc, nh, waited);
        cpu_req = 0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_write;
        cpu_req = 1; cpu_we = 1; cpu_addr = 5'd7; cpu_wdata = 8'h77;
        tick();
        total++;
        if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'd7) begin
            bad++;
            $display("FAIL midrst_pre: got gnt=%b we=%b addr=%0d required 1 1 7", cpu_gnt, mem_we, mem_addr);
        end
        #2;
        reset = 1;
        #1;
        total++;
        if (mem_we !== 1'b0 || cpu_gnt !== 1'b0 || host_gnt !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async: got we=%b gnt=%b hgnt=%b required 0 0 0", mem_we, cpu_gnt, host_gnt);
        end
        total++;
        if (mem_addr !== '0 || mem_wdata !== '0 || cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs: got addr=%0d wdata=%0h rv=%b hrv=%b required 0 0 0 0",
                     mem_addr, mem_wdata, cpu_rvalid, host_rvalid);
        end
        cpu_req = 0; cpu_we = 0;
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (cpu_gnt !== 1'b0 || mem_we !== 1'b0) begin
                bad++;
                $display("FAIL midrst_no_retry: got gnt=%b we=%b at cycle %0d required 0 0", cpu_gnt, mem_we, i);
            end
        end
        total++;
        if (ram[7] !== 8'h00) begin
            bad++;
            $display("FAIL midrst_ram: got ram[7]=%0h required 00", ram[7]);
        end
        $display("reset during cpu write: ram[7]=%0h", ram[7]);
    endtask

    initial begin
        reset    = 1;
        ram_init = 1;
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_host_write_read();
        test_both_requests();
        test_host_lock();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
